// File: rtl/iob_rr_arbiter_pkg.sv
// iob_rr_arbiter_pkg
//   Shared widths and the round-robin selection helper used by the IOb
//   round-robin arbiter and its read-ID FIFO.
//   No ports; import with `import iob_rr_arbiter_pkg::*;`.
package iob_rr_arbiter_pkg;

  // Widest supported requester set; the pick helper works on this width.
  localparam int unsigned MAX_MASTERS = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Master index width (ID_W = $clog2(N_MASTERS)).
  function automatic int unsigned id_w(input int unsigned n);
    return $clog2(n);
  endfunction

  // Outstanding-read counter width (CNT_W = $clog2(MAX_RD)+1).
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // First set bit of elig scanning ptr, ptr+1, ... modulo n.
  function automatic rr_pick_t rr_first(input logic [MAX_MASTERS-1:0] elig,
                                        input logic [2:0]             ptr,
                                        input int unsigned            n);
    rr_pick_t    r;
    int unsigned k;
    r = '0;
    for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
      if (i < n && !r.found) begin
        k = (32'(ptr) + i) % n;
        if (elig[3'(k)]) begin
          r.found = 1'b1;
          r.idx   = 3'(k);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/iob_arb_id_fifo.sv
// iob_arb_id_fifo
//   Register-based in-order FIFO holding the master ID of each accepted read.
//   Ports:
//     clk_i, cke_i, rst_i : clock, clock enable, synchronous active-high reset
//     push_i / din_i      : write one ID (ignored when full)
//     pop_i  / dout_o     : head ID, removed on pop (ignored when empty)
//     full_o, empty_o     : occupancy flags
//     count_o             : registered occupancy
module iob_arb_id_fifo #(
  parameter int unsigned ID_W  = 1,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             cke_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [ID_W-1:0]  din_i,
  output logic [ID_W-1:0]  dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (cke_i) begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: only entries between rd and wr are ever read.
  always_ff @(posedge clk_i) begin
    if (cke_i && do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/iob_rr_arbiter.sv
// iob_rr_arbiter
//   Round-robin arbiter sharing one IOb slave port between N_MASTERS masters.
//   The grant is held while the slave stalls; read IDs are queued in order so
//   each read response is routed back to its issuer.
//   Ports:
//     clk_i, cke_i, rst_i      : clock, clock enable, sync active-high reset
//     m_avalid_i/addr/wdata/wstrb : per-master requests (slice k = master k)
//     m_ready_o, m_rvalid_o    : per-master accept / read-valid (one-hot)
//     m_rdata_o                : read data broadcast to all masters
//     s_*                      : shared slave request/response port
//     rd_pending_o             : outstanding reads (registered)
//     err_o                    : sticky, response seen with no read outstanding
module iob_rr_arbiter
  import iob_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_RD    = 4
) (
  input  logic                          clk_i,
  input  logic                          cke_i,
  input  logic                          rst_i,
  input  logic [N_MASTERS-1:0]          m_avalid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb_i,
  output logic [N_MASTERS-1:0]          m_ready_o,
  output logic [N_MASTERS-1:0]          m_rvalid_o,
  output logic [DATA_W-1:0]             m_rdata_o,
  output logic                          s_avalid_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_wdata_o,
  output logic [DATA_W/8-1:0]           s_wstrb_o,
  input  logic                          s_ready_i,
  input  logic                          s_rvalid_i,
  input  logic [DATA_W-1:0]             s_rdata_i,
  output logic [$clog2(MAX_RD):0]       rd_pending_o,
  output logic                          err_o
);

  localparam int unsigned ID_W  = id_w(N_MASTERS);
  localparam int unsigned CNT_W = cnt_w(MAX_RD);
  localparam int unsigned SW    = DATA_W / 8;

  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      gnt_q, gnt_d;
  logic                 lock_q, lock_d;
  logic                 err_q, err_d;

  logic [N_MASTERS-1:0] elig;
  rr_pick_t             pick;
  logic [ID_W-1:0]      gnt_idx;
  logic                 gnt_vld;
  logic                 accept, push, pop;
  logic                 fifo_full, fifo_empty;
  logic [ID_W-1:0]      fifo_dout;

  // A read is masked while the ID FIFO is full, even if a pop happens in the
  // same cycle; the read is then taken one cycle later.
  always_comb begin
    elig = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      elig[k] = m_avalid_i[k] & ~((m_wstrb_i[k*SW +: SW] == '0) & fifo_full);
    end
  end

  assign pick    = rr_first(MAX_MASTERS'(elig), 3'(ptr_q), N_MASTERS);
  assign gnt_idx = lock_q ? gnt_q : ID_W'(pick.idx);
  assign gnt_vld = lock_q ? elig[gnt_q] : pick.found;

  assign s_avalid_o = gnt_vld;
  assign s_addr_o   = gnt_vld ? m_addr_i[gnt_idx*ADDR_W +: ADDR_W]  : '0;
  assign s_wdata_o  = gnt_vld ? m_wdata_i[gnt_idx*DATA_W +: DATA_W] : '0;
  assign s_wstrb_o  = gnt_vld ? m_wstrb_i[gnt_idx*SW +: SW]         : '0;

  assign accept    = gnt_vld & s_ready_i;
  assign push      = accept & (s_wstrb_o == '0);
  assign pop       = s_rvalid_i & ~fifo_empty;
  assign m_ready_o = accept ? (N_MASTERS'(1) << gnt_idx) : '0;

  assign m_rvalid_o = pop ? (N_MASTERS'(1) << fifo_dout) : '0;
  assign m_rdata_o  = s_rdata_i;
  assign err_o      = err_q;

  always_comb begin
    ptr_d  = ptr_q;
    gnt_d  = gnt_q;
    lock_d = lock_q;
    err_d  = err_q | (s_rvalid_i & fifo_empty);
    if (gnt_vld) begin
      if (s_ready_i) begin
        lock_d = 1'b0;
        ptr_d  = (gnt_idx == ID_W'(N_MASTERS - 1)) ? '0 : gnt_idx + ID_W'(1);
      end else begin
        lock_d = 1'b1;
        gnt_d  = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q  <= '0;
      gnt_q  <= '0;
      lock_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (cke_i) begin
      ptr_q  <= ptr_d;
      gnt_q  <= gnt_d;
      lock_q <= lock_d;
      err_q  <= err_d;
    end
  end

  iob_arb_id_fifo #(
    .ID_W  (ID_W),
    .DEPTH (MAX_RD),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .cke_i   (cke_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (gnt_idx),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (rd_pending_o)
  );

endmodule

// File: tb/tb_iob_rr_arbiter.sv
module tb_iob_rr_arbiter;
  localparam int N = 2, ADDR_W = 32, DATA_W = 32, MAX_RD = 4, SW = DATA_W / 8;

  logic clk = 0, cke = 1, rst = 1;
  logic [N-1:0]        avalid = '0;
  logic [N*ADDR_W-1:0] addr   = '0;
  logic [N*DATA_W-1:0] wdata  = '0;
  logic [N*SW-1:0]     wstrb  = '0;
  logic s_ready = 0, s_rvalid = 0;
  logic [DATA_W-1:0] s_rdata = '0;

  logic [N-1:0] m_ready, m_rvalid;
  logic [DATA_W-1:0] m_rdata, s_wdata;
  logic s_avalid, err;
  logic [ADDR_W-1:0] s_addr;
  logic [SW-1:0] s_wstrb;
  logic [$clog2(MAX_RD):0] rd_pending;

  int n_cmp = 0, n_bad = 0;

  // Reference model state: next-to-scan pointer, held grant, pending read IDs.
  int m_ptr = 0, m_gidx = 0;
  bit m_lock = 0, m_err = 0;
  int mq[$];
  bit exp_gv; int exp_g;
  logic [ADDR_W-1:0] exp_addr; logic [DATA_W-1:0] exp_wdata; logic [SW-1:0] exp_wstrb;
  logic [N-1:0] exp_mready, exp_rvalid;

  iob_rr_arbiter #(.N_MASTERS(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RD(MAX_RD)) dut (
    .clk_i(clk), .cke_i(cke), .rst_i(rst),
    .m_avalid_i(avalid), .m_addr_i(addr), .m_wdata_i(wdata), .m_wstrb_i(wstrb),
    .m_ready_o(m_ready), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
    .s_avalid_o(s_avalid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
    .s_ready_i(s_ready), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .rd_pending_o(rd_pending), .err_o(err));

  always #5 clk = ~clk;

  task automatic model_eval();
    bit el[N];
    int qs = mq.size();
    for (int k = 0; k < N; k++)
      el[k] = avalid[k] && !((wstrb[k*SW +: SW] == 0) && qs == MAX_RD);
    exp_gv = 0; exp_g = 0;
    if (m_lock) begin
      exp_gv = el[m_gidx]; exp_g = m_gidx;
    end else begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (!exp_gv && el[k]) begin exp_gv = 1; exp_g = k; end
      end
    end
    exp_addr   = exp_gv ? addr[exp_g*ADDR_W +: ADDR_W]  : '0;
    exp_wdata  = exp_gv ? wdata[exp_g*DATA_W +: DATA_W] : '0;
    exp_wstrb  = exp_gv ? wstrb[exp_g*SW +: SW]         : '0;
    exp_mready = (exp_gv && s_ready) ? N'(1 << exp_g) : '0;
    exp_rvalid = (s_rvalid && qs > 0) ? N'(1 << mq[0]) : '0;
  endtask

  task automatic model_commit();
    if (rst) begin
      m_ptr = 0; m_lock = 0; m_gidx = 0; m_err = 0; mq.delete();
      return;
    end
    if (!cke) return;
    if (s_rvalid) begin
      if (mq.size() > 0) void'(mq.pop_front());
      else m_err = 1;
    end
    if (exp_gv) begin
      if (s_ready) begin
        m_lock = 0; m_ptr = (exp_g + 1) % N;
        if (exp_wstrb == 0) mq.push_back(exp_g);
      end else begin
        m_lock = 1; m_gidx = exp_g;
      end
    end
  endtask

  // Advance one clock, keeping the model in step with the DUT.
  task automatic tick();
    model_eval();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic set_m(input int k, input bit av, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] wd, input logic [SW-1:0] ws);
    avalid[k] = av;
    addr[k*ADDR_W +: ADDR_W] = a;
    wdata[k*DATA_W +: DATA_W] = wd;
    wstrb[k*SW +: SW] = ws;
  endtask

  task automatic idle();
    avalid = '0; addr = '0; wdata = '0; wstrb = '0;
    s_ready = 0; s_rvalid = 0; s_rdata = '0; cke = 1; rst = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1; tick(); rst = 0; #1;
    n_cmp++; if (s_avalid !== 1'b0) begin n_bad++; $display("FAIL reset_savalid got %b want 0", s_avalid); end
    n_cmp++; if (m_ready !== '0) begin n_bad++; $display("FAIL reset_mready got %b want 0", m_ready); end
    n_cmp++; if (m_rvalid !== '0) begin n_bad++; $display("FAIL reset_rvalid got %b want 0", m_rvalid); end
    n_cmp++; if (rd_pending !== 0) begin n_bad++; $display("FAIL reset_pending got %0d want 0", rd_pending); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
  endtask

  task automatic test_single_read();
    idle(); set_m(1, 1, 32'h10, '0, '0); s_ready = 1; #1;
    n_cmp++; if (m_ready !== 2'b10) begin n_bad++; $display("FAIL single_ready got %b want 10", m_ready); end
    n_cmp++; if (s_addr !== 32'h10) begin n_bad++; $display("FAIL single_addr got %h want 10", s_addr); end
    tick(); idle(); #1;
    n_cmp++; if (rd_pending !== 1) begin n_bad++; $display("FAIL single_pend1 got %0d want 1", rd_pending); end
    tick(); s_rvalid = 1; s_rdata = 32'hDEADBEEF; #1;
    n_cmp++; if (m_rvalid !== 2'b10) begin n_bad++; $display("FAIL single_rvalid got %b want 10", m_rvalid); end
    n_cmp++; if (m_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_rdata got %h want deadbeef", m_rdata); end
    tick(); idle(); #1;
    n_cmp++; if (rd_pending !== 0) begin n_bad++; $display("FAIL single_pend0 got %0d want 0", rd_pending); end
  endtask

  task automatic test_fairness();
    int acc[N];
    acc[0] = 0; acc[1] = 0;
    idle(); s_ready = 1;
    set_m(0, 1, 32'hA0, 32'h1111, 4'hF); set_m(1, 1, 32'hB0, 32'h2222, 4'hF);
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if (m_ready !== N'(1 << (i % 2))) begin n_bad++; $display("FAIL fair_grant c%0d got %b want %b", i, m_ready, N'(1 << (i % 2))); end
      for (int k = 0; k < N; k++) if (m_ready[k]) acc[k]++;
      tick();
    end
    n_cmp++; if (acc[0] != 4 || acc[1] != 4) begin n_bad++; $display("FAIL fair_count got %0d/%0d want 4/4", acc[0], acc[1]); end
    idle();
  endtask

  task automatic test_stall_lock();
    idle();
    set_m(0, 1, 32'hC0, 32'h3, 4'hF); set_m(1, 1, 32'hD0, 32'h4, 4'hF);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (s_avalid !== 1'b1 || s_addr !== 32'hC0 || m_ready !== '0) begin
        n_bad++; $display("FAIL stall_hold c%0d got av=%b addr=%h rdy=%b want av=1 addr=c0 rdy=00", i, s_avalid, s_addr, m_ready); end
      tick();
      if (i == 1) begin addr[ADDR_W +: ADDR_W] = 32'hD4; #1; end
    end
    s_ready = 1; #1;
    n_cmp++; if (m_ready !== 2'b01) begin n_bad++; $display("FAIL stall_accept got %b want 01", m_ready); end
    tick(); #1;
    n_cmp++; if (m_ready !== 2'b10 || s_addr !== 32'hD4) begin n_bad++; $display("FAIL stall_next got rdy=%b addr=%h want 10/d4", m_ready, s_addr); end
    tick(); idle();
  endtask

  task automatic test_full();
    idle(); s_ready = 1; set_m(0, 1, 32'h40, '0, '0);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (m_ready !== 2'b01) begin n_bad++; $display("FAIL full_fill c%0d got %b want 01", i, m_ready); end
      tick();
    end
    #1;
    n_cmp++; if (s_avalid !== 1'b0 || rd_pending !== 4) begin n_bad++; $display("FAIL full_block got av=%b pend=%0d want 0/4", s_avalid, rd_pending); end
    set_m(1, 1, 32'h50, 32'h5, 4'h3); #1;
    n_cmp++; if (m_ready !== 2'b10) begin n_bad++; $display("FAIL full_write got %b want 10", m_ready); end
    tick(); set_m(1, 0, '0, '0, '0); s_rvalid = 1; s_rdata = 32'h77; #1;
    n_cmp++; if (s_avalid !== 1'b0 || m_rvalid !== 2'b01) begin n_bad++; $display("FAIL full_popcycle got av=%b rv=%b want 0/01", s_avalid, m_rvalid); end
    tick(); s_rvalid = 0; #1;
    n_cmp++; if (m_ready !== 2'b01) begin n_bad++; $display("FAIL full_fifth got %b want 01", m_ready); end
    tick(); avalid = '0; #1;
    n_cmp++; if (rd_pending !== 4) begin n_bad++; $display("FAIL full_pend got %0d want 4", rd_pending); end
    s_rvalid = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (m_rvalid !== 2'b01) begin n_bad++; $display("FAIL full_drain c%0d got %b want 01", i, m_rvalid); end
      tick();
    end
    idle();
  endtask

  task automatic test_ordering();
    int ids[3];
    logic [DATA_W-1:0] dat[3];
    ids[0] = 1; ids[1] = 0; ids[2] = 1;
    dat[0] = 32'hAAAA0001; dat[1] = 32'hBBBB0002; dat[2] = 32'hCCCC0003;
    for (int i = 0; i < 3; i++) begin
      idle(); s_ready = 1; set_m(ids[i], 1, 32'(i * 4), '0, '0); #1;
      n_cmp++; if (m_ready !== N'(1 << ids[i])) begin n_bad++; $display("FAIL order_issue%0d got %b want %b", i, m_ready, N'(1 << ids[i])); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      idle(); s_rvalid = 1; s_rdata = dat[i]; #1;
      n_cmp++; if (m_rvalid !== N'(1 << ids[i]) || m_rdata !== dat[i]) begin
        n_bad++; $display("FAIL order_resp%0d got rv=%b d=%h want %b/%h", i, m_rvalid, m_rdata, N'(1 << ids[i]), dat[i]); end
      tick();
    end
    idle();
  endtask

  task automatic test_spurious_reset();
    idle(); s_rvalid = 1; #1;
    n_cmp++; if (m_rvalid !== '0) begin n_bad++; $display("FAIL spur_rvalid got %b want 00", m_rvalid); end
    tick(); idle(); #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL spur_err got %b want 1", err); end
    s_ready = 1; set_m(0, 1, 32'h60, '0, '0); tick(); tick(); idle(); #1;
    n_cmp++; if (rd_pending !== 2 || err !== 1'b1) begin n_bad++; $display("FAIL spur_pend got %0d/%b want 2/1", rd_pending, err); end
    rst = 1; tick(); rst = 0; #1;
    n_cmp++; if (rd_pending !== 0 || err !== 1'b0) begin n_bad++; $display("FAIL rst_clear got %0d/%b want 0/0", rd_pending, err); end
    s_rvalid = 1; tick(); s_rvalid = 0; #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL rst_late_resp got %b want 1", err); end
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      #1;
      n_cmp++; if (rd_pending !== mq.size() || err !== m_err) begin
        n_bad++; $display("FAIL rand_state c%0d got pend=%0d err=%b want %0d/%b", c, rd_pending, err, mq.size(), m_err); end
      for (int k = 0; k < N; k++)
        set_m(k, $urandom_range(0, 99) < 60, $urandom, $urandom,
              ($urandom_range(0, 1) == 1) ? '0 : SW'($urandom_range(1, 15)));
      s_ready  = $urandom_range(0, 99) < 55;
      s_rvalid = $urandom_range(0, 99) < 35;
      s_rdata  = $urandom;
      cke      = $urandom_range(0, 99) < 90;
      rst      = $urandom_range(0, 199) == 0;
      #1; model_eval();
      n_cmp++; if (s_avalid !== exp_gv || s_addr !== exp_addr || s_wdata !== exp_wdata || s_wstrb !== exp_wstrb) begin
        n_bad++; $display("FAIL rand_req c%0d got av=%b a=%h w=%h s=%h want %b/%h/%h/%h", c, s_avalid, s_addr, s_wdata, s_wstrb, exp_gv, exp_addr, exp_wdata, exp_wstrb); end
      n_cmp++; if (m_ready !== exp_mready) begin n_bad++; $display("FAIL rand_ready c%0d got %b want %b", c, m_ready, exp_mready); end
      n_cmp++; if (m_rvalid !== exp_rvalid || m_rdata !== s_rdata) begin
        n_bad++; $display("FAIL rand_resp c%0d got rv=%b d=%h want %b/%h", c, m_rvalid, m_rdata, exp_rvalid, s_rdata); end
      tick();
    end
    idle();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_read();
    test_fairness();
    test_stall_lock();
    test_full();
    test_ordering();
    test_spurious_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
